// File: rtl/demux14_tdm.sv
// demux14_tdm: TDM 1:4 demux, HUNT/LOCK slot tracking off a frame-sync marker.
// Build option: DEMUX14_TDM_ERR_EN enables the sticky framing-error flag on oerr.
module demux14_tdm #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] id,
  input  logic             iv,
  input  logic             isync,
  output logic [WIDTH-1:0] oz0,
  output logic [WIDTH-1:0] oz1,
  output logic [WIDTH-1:0] oz2,
  output logic [WIDTH-1:0] oz3,
  output logic [3:0]       ostb,
  output logic             ofrm,
  output logic             olock,
  output logic [1:0]       oslot,
  output logic             oerr
);

  localparam logic HUNT = 1'b0;
  localparam logic LOCK = 1'b1;

  logic             state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] oz_q [4];
  logic [WIDTH-1:0] oz_d [4];
  logic [3:0]       ostb_q, ostb_d;
  logic             ofrm_q, ofrm_d;

  logic sync_w, data_w, hunt_w, lock_w;

  assign sync_w = iv && isync;
  assign data_w = iv && !isync;
  assign hunt_w = state_q == HUNT;
  assign lock_w = state_q == LOCK;

  // Next-state: slot tracking, channel steering and one-cycle pulses
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    oz_d    = oz_q;
    ostb_d  = 4'b0000;
    ofrm_d  = 1'b0;
    unique case (1'b1)
      !iv: ;
      sync_w: begin
        oz_d[0] = id;
        ostb_d  = 4'b0001;
        slot_d  = 2'd1;
        state_d = LOCK;
      end
      data_w && hunt_w: ;
      data_w && lock_w && slot_q == 2'd0: begin
        state_d = HUNT;
        slot_d  = 2'd0;
      end
      default: begin
        oz_d[slot_q] = id;
        ostb_d       = 4'b0001 << slot_q;
        ofrm_d       = slot_q == 2'd3;
        slot_d       = slot_q + 2'd1;
      end
    endcase
  end

  // State, slot and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      for (int i = 0; i < 4; i++) oz_q[i] <= '0;
      ostb_q  <= 4'b0000;
      ofrm_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      oz_q    <= oz_d;
      ostb_q  <= ostb_d;
      ofrm_q  <= ofrm_d;
    end
  end

`ifdef DEMUX14_TDM_ERR_EN
  logic err_q, err_d, err_evt;

  // Early sync inside a frame, or a missing sync where slot 0 is due
  always_comb begin
    err_evt = 1'b0;
    if (iv && lock_w) begin
      err_evt = isync ? (slot_q != 2'd0) : (slot_q == 2'd0);
    end
    err_d = err_q || err_evt;
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign oerr = err_q;
`else
  assign oerr = 1'b0;
`endif

  assign oz0   = oz_q[0];
  assign oz1   = oz_q[1];
  assign oz2   = oz_q[2];
  assign oz3   = oz_q[3];
  assign ostb  = ostb_q;
  assign ofrm  = ofrm_q;
  assign olock = state_q;
  assign oslot = slot_q;

endmodule

// File: tb/tb_demux14_tdm.sv
// tb_demux14_tdm: directed plan plus random traffic vs a frame-level model.
// Model tracks "locked" and "next slot" as plain integers per word.
module tb_demux14_tdm;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] id = '0;
  logic         iv = 1'b0;
  logic         isync = 1'b0;
  logic [W-1:0] oz0, oz1, oz2, oz3;
  logic [3:0]   ostb;
  logic         ofrm, olock, oerr;
  logic [1:0]   oslot;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

`ifdef DEMUX14_TDM_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  demux14_tdm #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .id(id), .iv(iv), .isync(isync),
    .oz0(oz0), .oz1(oz1), .oz2(oz2), .oz3(oz3),
    .ostb(ostb), .ofrm(ofrm), .olock(olock),
    .oslot(oslot), .oerr(oerr)
  );

  always #5 clk = ~clk;

  // frame-level reference
  bit       m_lock = 0;
  int       m_next = 0;
  int       m_oz [4] = '{0, 0, 0, 0};
  int       m_stb = 0;
  bit       m_frm = 0;
  bit       m_err = 0;

  always @(posedge clk) begin
    m_stb = 0;
    m_frm = 0;
    if (rst) begin
      m_lock = 0; m_next = 0; m_err = 0;
      for (int i = 0; i < 4; i++) m_oz[i] = 0;
    end else if (iv) begin
      if (isync) begin
        if (m_lock && m_next != 0) m_err = 1;
        m_oz[0] = int'(id);
        m_stb = 1;
        m_next = 1;
        m_lock = 1;
      end else if (m_lock) begin
        if (m_next == 0) begin
          m_lock = 0;
          m_err = 1;
        end else begin
          m_oz[m_next] = int'(id);
          m_stb = 2 ** m_next;
          m_frm = (m_next == 3);
          m_next = (m_next + 1) % 4;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("oz0", int'(oz0), m_oz[0]);
      chk("oz1", int'(oz1), m_oz[1]);
      chk("oz2", int'(oz2), m_oz[2]);
      chk("oz3", int'(oz3), m_oz[3]);
      chk("ostb", int'(ostb), m_stb);
      chk("ofrm", int'(ofrm), int'(m_frm));
      chk("olock", int'(olock), int'(m_lock));
      chk("oslot", int'(oslot), m_next);
      chk("oerr", int'(oerr), ERR_BUILD ? int'(m_err) : 0);
    end
  end

  task automatic step(input bit r, input bit v, input bit s, input int d);
    rst = r; iv = v; isync = s; id = W'(d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic chk_oz(input string nm, input int a, input int b,
                        input int c, input int d);
    chk({nm, ".oz0"}, int'(oz0), a);
    chk({nm, ".oz1"}, int'(oz1), b);
    chk({nm, ".oz2"}, int'(oz2), c);
    chk({nm, ".oz3"}, int'(oz3), d);
  endtask

  initial begin
    step(1, 0, 0, 0);
    chk_on = 1'b1;
    step(1, 0, 0, 0);
    chk_oz("rst", 0, 0, 0, 0);
    chk("rst.ostb", int'(ostb), 0);
    chk("rst.olock", int'(olock), 0);
    chk("rst.oslot", int'(oslot), 0);
    chk("rst.oerr", int'(oerr), 0);

    step(0, 1, 1, 1);
    chk("b2b.stb0", int'(ostb), 1);
    step(0, 1, 0, 2);
    chk("b2b.stb1", int'(ostb), 2);
    step(0, 1, 0, 3);
    chk("b2b.stb2", int'(ostb), 4);
    chk("b2b.frm_early", int'(ofrm), 0);
    step(0, 1, 0, 4);
    chk("b2b.stb3", int'(ostb), 8);
    chk("b2b.frm", int'(ofrm), 1);
    chk_oz("b2b", 1, 2, 3, 4);
    chk("b2b.lock", int'(olock), 1);
    idle(1);
    chk("b2b.frm_drop", int'(ofrm), 0);

    step(0, 1, 1, 10); idle(2);
    step(0, 1, 0, 11); idle(2);
    step(0, 1, 0, 12); idle(2);
    chk_oz("gap_hold", 10, 11, 12, 4);
    step(0, 1, 0, 13);
    chk("gap.frm", int'(ofrm), 1);
    chk_oz("gap", 10, 11, 12, 13);

    step(1, 0, 0, 0);
    step(0, 1, 0, 7);
    step(0, 1, 0, 8);
    chk_oz("nosync", 0, 0, 0, 0);
    chk("nosync.lock", int'(olock), 0);
    step(0, 1, 1, 5);
    chk("nosync.oz0", int'(oz0), 5);
    chk("nosync.lock1", int'(olock), 1);

    step(1, 0, 0, 0);
    step(0, 1, 1, 1);
    step(0, 1, 0, 2);
    step(0, 1, 0, 3);
    step(0, 1, 1, 9);
    chk_oz("early", 9, 2, 3, 0);
    chk("early.slot", int'(oslot), 1);
    chk("early.frm", int'(ofrm), 0);
    chk("early.err", int'(oerr), ERR_BUILD ? 1 : 0);

    step(1, 0, 0, 0);
    step(0, 1, 1, 1);
    step(0, 1, 0, 2);
    step(0, 1, 0, 3);
    step(0, 1, 0, 4);
    step(0, 1, 0, 6);
    chk("miss.lock", int'(olock), 0);
    chk("miss.stb", int'(ostb), 0);
    chk_oz("miss", 1, 2, 3, 4);
    chk("miss.err", int'(oerr), ERR_BUILD ? 1 : 0);

    step(0, 1, 1, 1);
    step(0, 1, 0, 2);
    step(1, 1, 0, 3);
    chk_oz("midrst", 0, 0, 0, 0);
    chk("midrst.err", int'(oerr), 0);
    chk("midrst.lock", int'(olock), 0);
    step(0, 1, 1, 5);
    step(0, 1, 0, 6);
    step(0, 1, 0, 7);
    step(0, 1, 0, 8);
    chk("after.frm", int'(ofrm), 1);
    chk_oz("after", 5, 6, 7, 8);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) == 0),
           ($urandom_range(3) != 0),
           ($urandom_range(4) == 0),
           int'($urandom_range(15)));
    end
    idle(2);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
